// File: rtl/i2s_tx_stereo.sv
// I2S / left-justified stereo transmitter, master mode, single clock aud_xck.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module i2s_tx_stereo #(
    parameter int DATA_W  = 16,
    parameter int SLOT_W  = 32,
    parameter int BCK_DIV = 3,
    parameter int JUSTIFY = 0
) (
    input  logic              aud_xck,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              aud_bck,
    output logic              aud_lrck,
    output logic              aud_data,
    output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_W);
    localparam logic [BW-1:0] LAST = BW'(2 * SLOT_W - 1);
    localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W - 1) {1'b0}}};

    generate
        if (JUSTIFY == 0 && DATA_W > SLOT_W - 1) begin : g_cfg_err
            $error("i2s_tx_stereo: DATA_W must not exceed SLOT_W-1 in I2S mode");
        end
    endgenerate

    logic [DW-1:0]     r_div;
    logic              r_bck;
    logic [BW-1:0]     r_bit;
    logic              r_lrck;
    logic              r_data;
    logic              r_underrun;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic [DATA_W-1:0] r_buf_l;
    logic [DATA_W-1:0] r_buf_r;

    logic              w_tick;
    logic              w_fall;
    logic              w_fstart;
    logic              w_accept;
    logic [BW-1:0]     w_bit_nxt;
    logic              w_lrck_nxt;
    logic [BW-1:0]     w_k;
    logic [BW-1:0]     w_sh_amt;
    logic              w_bit_ok;
    logic [DATA_W-1:0] w_buf_l_nxt;
    logic [DATA_W-1:0] w_buf_r_nxt;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_mask;
    logic              w_data_nxt;

    assign w_tick   = (r_div == DW'(BCK_DIV - 1));
    assign w_fall   = w_tick && r_bck;
    assign w_fstart = w_fall && (r_bit == LAST);
    assign w_accept = s_valid && !r_hold_full;

    // Next slot position, next buffer contents and the bit that goes out with them
    always_comb begin
        w_buf_l_nxt = r_buf_l;
        w_buf_r_nxt = r_buf_r;
        w_bit_ok    = 1'b0;
        w_sh_amt    = '0;
        if (w_fstart) begin
            w_buf_l_nxt = r_hold_full ? r_hold_l : '0;
            w_buf_r_nxt = r_hold_full ? r_hold_r : '0;
        end
        w_bit_nxt  = (r_bit == LAST) ? '0 : r_bit + BW'(1);
        w_lrck_nxt = (w_bit_nxt >= BW'(SLOT_W));
        w_k        = w_lrck_nxt ? w_bit_nxt - BW'(SLOT_W) : w_bit_nxt;
        w_word     = w_lrck_nxt ? w_buf_r_nxt : w_buf_l_nxt;
        if (JUSTIFY != 0) begin
            w_bit_ok = (w_k < BW'(DATA_W));
            w_sh_amt = w_k;
        end else begin
            w_bit_ok = (w_k != '0) && (w_k <= BW'(DATA_W));
            w_sh_amt = w_k - BW'(1);
        end
        w_mask     = MSB >> w_sh_amt;
        w_data_nxt = w_bit_ok && |(w_word & w_mask);
    end

    // BCK divider: toggle aud_bck every BCK_DIV master clocks
    always_ff @(posedge aud_xck or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_bck <= 1'b0;
        end else if (w_tick) begin
            r_div <= '0;
            r_bck <= ~r_bck;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Bit position, word select and serial data move together on BCK falls
    always_ff @(posedge aud_xck or negedge reset_n) begin
        if (!reset_n) begin
            r_bit  <= LAST;
            r_lrck <= 1'b0;
            r_data <= 1'b0;
        end else if (w_fall) begin
            r_bit  <= w_bit_nxt;
            r_lrck <= w_lrck_nxt;
            r_data <= w_data_nxt;
        end
    end

    // One-entry hold register; emptied only when a frame consumes it
    always_ff @(posedge aud_xck or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_l    <= s_left;
            r_hold_r    <= s_right;
        end else if (w_fstart) begin
            r_hold_full <= 1'b0;
        end
    end

    // Shift buffers are frozen for the whole frame
    always_ff @(posedge aud_xck or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_l <= '0;
            r_buf_r <= '0;
        end else begin
            r_buf_l <= w_buf_l_nxt;
            r_buf_r <= w_buf_r_nxt;
        end
    end

    // Single-cycle flag when a frame starts with nothing held
    always_ff @(posedge aud_xck or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_fstart && !r_hold_full;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] r_ur_cnt;

    // Saturating count of underrun events
    always_ff @(posedge aud_xck or negedge reset_n) begin
        if (!reset_n) begin
            r_ur_cnt <= '0;
        end else if (w_fstart && !r_hold_full && r_ur_cnt != 16'hFFFF) begin
            r_ur_cnt <= r_ur_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_ur_cnt;
`endif

    assign s_ready  = !r_hold_full;
    assign aud_bck  = r_bck;
    assign aud_lrck = r_lrck;
    assign aud_data = r_data;
    assign underrun = r_underrun;

endmodule

// File: doc/i2s_tx_stereo.md
I2S_TX_STEREO -- requirements
Module: i2s_tx_stereo

Interface
REQ-001 Parameter DATA_W, default 16, meaning bits per audio sample (2..SLOT_W).
REQ-002 Parameter SLOT_W, default 32, meaning BCK periods per channel slot; frame = 2*SLOT_W BCK periods.
REQ-003 Parameter BCK_DIV, default 3, meaning aud_xck cycles per BCK half-period (>=1).
REQ-004 Parameter JUSTIFY, default 0, meaning 0 = I2S (MSB one BCK after LRCK edge), 1 = left-justified (MSB on LRCK edge).
REQ-005 aud_xck  input  1  master clock; sole clock of the block.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 s_valid  input  1  stereo sample offered.
REQ-008 s_ready  output  1  block can accept a sample.
REQ-009 s_left  input  DATA_W  left sample, two's complement.
REQ-010 s_right  input  DATA_W  right sample, two's complement.
REQ-011 aud_bck  output  1  bit clock, registered.
REQ-012 aud_lrck  output  1  word select; 0 = left slot, 1 = right slot.
REQ-013 aud_data  output  1  serial data, MSB first.
REQ-014 underrun  output  1  one-aud_xck pulse when a frame starts with no sample held.

Function
REQ-015 Divider counts 0..BCK_DIV-1 on aud_xck; at terminal count it wraps and toggles aud_bck; BCK period = 2*BCK_DIV aud_xck cycles.
REQ-016 "BCK fall" = aud_xck cycle in which aud_bck toggles 1->0; aud_lrck and aud_data change only in BCK-fall cycles.
REQ-017 Bit counter 0..2*SLOT_W-1 advances by 1 on each BCK fall, wrapping to 0; wrap-to-0 is "frame start".
REQ-018 aud_lrck = 0 while bit counter < SLOT_W, else 1; k = bit counter mod SLOT_W.
REQ-019 Hold register, one entry (L,R): s_ready = !hold_full; transfer when s_valid && s_ready; hold_full set next cycle.
REQ-020 At frame start with hold_full: hold copies into shift buffer, hold_full clears; s_ready rises the following cycle.
REQ-021 At frame start with hold empty: shift buffer loads zeros; underrun pulses for exactly that cycle.
REQ-022 Accept coinciding with frame start while hold empty: sample goes to hold, not used this frame, underrun still pulses.
REQ-023 JUSTIFY=1: aud_data = word[DATA_W-1-k] for k < DATA_W, else 0.
REQ-024 JUSTIFY=0: aud_data = word[DATA_W-k] for 1 <= k <= DATA_W, else 0; DATA_W > SLOT_W-1 is a configuration error.
REQ-025 word = left buffer when aud_lrck=0, right buffer when 1; buffer contents constant for the whole frame.

Reset
REQ-026 reset_n low: aud_bck=0, aud_lrck=0, aud_data=0, underrun=0, hold_full=0 (s_ready=1), buffers=0, divider=0, bit counter=2*SLOT_W-1.
REQ-027 First BCK fall after reset release is a frame start (REQ-020/021 apply).
REQ-028 Reset asserted mid-frame aborts the frame immediately; held sample is discarded.

Configuration
REQ-029 Macro I2S_TX_UNDERRUN_CNT_EN defined: adds output underrun_cnt[15:0], +1 per underrun pulse, saturates at 16'hFFFF, reset to 0.
REQ-030 Macro undefined: underrun_cnt port and logic absent; all other behaviour identical.

Verification (DATA_W=16, SLOT_W=32, BCK_DIV=3: BCK=6 cycles, frame=384 cycles)
REQ-031 Reset, then idle -> aud_bck toggles every 3 cycles; aud_lrck period 384 cycles; aud_data=0; underrun pulses once per 384 cycles.
REQ-032 JUSTIFY=0, one sample L=16'hA5F0 R=16'h0F0F -> next frame: left k=1..16 carry A5F0 MSB first, right k=1..16 carry 0F0F, all other bits 0.
REQ-033 JUSTIFY=1, same sample -> MSB at k=0 of each slot; k=16..31 = 0.
REQ-034 s_valid held high with three samples -> s_ready low after first accept; exactly one sample per frame; no underrun after the first frame.
REQ-035 Sample offered coincident with frame-start cycle, hold empty -> underrun pulse, zero frame, sample sent in following frame.
REQ-036 reset_n pulsed mid-right-slot -> all outputs at REQ-026 values within the same cycle; with I2S_TX_UNDERRUN_CNT_EN, 3 underruns -> underrun_cnt=3, reset -> 0.
